// File: rtl/sharpen_window_gen.sv
// 3x3 sliding-window generator feeding a sharpen core: two line buffers plus a
// column-shift window register, single output register with AXI-Stream style handshakes.
module sharpen_window_gen #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_tvalid,
    output logic       s_tready,
    input  logic [7:0] s_tdata,
    input  logic       s_tuser,
    output logic       m_tvalid,
    input  logic       m_tready,
    output logic [7:0] m_p0,
    output logic [7:0] m_p1,
    output logic [7:0] m_p2,
    output logic [7:0] m_p3,
    output logic [7:0] m_p4,
    output logic [7:0] m_p5,
    output logic [7:0] m_p6,
    output logic [7:0] m_p7,
    output logic [7:0] m_p8,
    output logic       m_tlast
);

    localparam int MAX_DIM = (IMG_W > IMG_H) ? IMG_W : IMG_H;
    localparam int CW      = $clog2(MAX_DIM);
    localparam int AW      = $clog2(IMG_W);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   row, col, row_nxt, col_nxt;
    logic [CW-1:0]   row_eff, col_eff;
    logic [AW-1:0]   col_idx;
    logic            accept, take, emit, frame_end;
    logic [7:0]      top_px, mid_px;
    logic [7:0]      lb_a [IMG_W];
    logic [7:0]      lb_b [IMG_W];
    logic [2:0][2:0][7:0] win;

    // A start-of-frame pixel is always (0,0), whatever the counters say.
    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        col_nxt   = col;
        s_tready  = m_tready | ~m_tvalid;
        accept    = s_tvalid & s_tready;
        take      = accept & (s_tuser | (state == ACTIVE));
        row_eff   = s_tuser ? '0 : row;
        col_eff   = s_tuser ? '0 : col;
        frame_end = (row_eff == CW'(IMG_H - 1)) && (col_eff == CW'(IMG_W - 1));
        emit      = take && (row_eff >= CW'(2)) && (col_eff >= CW'(2));
        if (take) begin
            if (frame_end) begin
                state_nxt = IDLE;
                row_nxt   = '0;
                col_nxt   = '0;
            end else begin
                state_nxt = ACTIVE;
                if (col_eff == CW'(IMG_W - 1)) begin
                    col_nxt = '0;
                    row_nxt = row_eff + CW'(1);
                end else begin
                    col_nxt = col_eff + CW'(1);
                    row_nxt = row_eff;
                end
            end
        end
    end

    assign col_idx = col_eff[AW-1:0];
    assign top_px  = lb_a[col_idx];
    assign mid_px  = lb_b[col_idx];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            row   <= '0;
            col   <= '0;
        end else begin
            state <= state_nxt;
            row   <= row_nxt;
            col   <= col_nxt;
        end
    end

    // NOTE: line-buffer RAM has no reset; stale rows are never emitted because output waits for row>=2.
    always_ff @(posedge clk) begin
        if (take) begin
            lb_a[col_idx] <= mid_px;
            lb_b[col_idx] <= s_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win      <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            {m_p0, m_p1, m_p2, m_p3, m_p4, m_p5, m_p6, m_p7, m_p8} <= '0;
        end else begin
            if (take) begin
                for (int i = 0; i < 3; i++) begin
                    win[i][0] <= win[i][1];
                    win[i][1] <= win[i][2];
                end
                win[0][2] <= top_px;
                win[1][2] <= mid_px;
                win[2][2] <= s_tdata;
            end
            // Loading only happens on acceptance, which implies the register is free or draining.
            if (emit) begin
                m_tvalid <= 1'b1;
                m_tlast  <= frame_end;
                {m_p0, m_p1, m_p2} <= {win[0][1], win[0][2], top_px};
                {m_p3, m_p4, m_p5} <= {win[1][1], win[1][2], mid_px};
                {m_p6, m_p7, m_p8} <= {win[2][1], win[2][2], s_tdata};
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
                m_tlast  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sharpen_window_gen.sv
// Cycle-by-cycle check of sharpen_window_gen against a frame-buffer reference model
// on a 5x4 image: ramp frames, stalls, idle drops, restart, reset and back-to-back frames.
module tb_sharpen_window_gen;

    localparam int W = 5;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_tvalid, s_tready, s_tuser;
    logic [7:0] s_tdata;
    logic       m_tvalid, m_tready, m_tlast;
    logic [7:0] m_p0, m_p1, m_p2, m_p3, m_p4, m_p5, m_p6, m_p7, m_p8;

    always #5 clk = ~clk;

    sharpen_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tuser(s_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_p0(m_p0), .m_p1(m_p1), .m_p2(m_p2), .m_p3(m_p3), .m_p4(m_p4),
        .m_p5(m_p5), .m_p6(m_p6), .m_p7(m_p7), .m_p8(m_p8),
        .m_tlast(m_tlast)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int mode  = 0;      // 0: ready always, 1: ready pattern 1,0,0,1, 2: random ready
    bit gaps  = 0;      // insert random idle cycles between pixels

    // Reference model: pixels of the current frame stored by position.
    logic [7:0]  img [H][W];
    logic [71:0] exp_win;
    logic        exp_valid, exp_last;
    bit          m_active;
    int          m_r, m_c;

    logic [71:0] win_log [$];
    bit          last_log [$];

    wire [71:0] dut_win = {m_p0, m_p1, m_p2, m_p3, m_p4, m_p5, m_p6, m_p7, m_p8};

    localparam logic [71:0] RAMP_FIRST = 72'h00_01_02_0A_0B_0C_14_15_16;
    localparam logic [71:0] RAMP_LAST  = 72'h0C_0D_0E_16_17_18_20_21_22;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit next_rdy();
        case (mode)
            1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
            2:       return $urandom_range(0, 1) == 1;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        exp_valid = 0; exp_last = 0; exp_win = '0;
        m_active = 0; m_r = 0; m_c = 0;
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit u, input bit rdy,
                        input bit rst, output bit acc);
        bit loaded, deliver;
        s_tvalid = v; s_tdata = d; s_tuser = u; m_tready = rdy; rst_n = !rst;
        @(negedge clk);
        chk("m_tvalid", m_tvalid, exp_valid);
        chk("m_tlast", m_tlast, exp_last);
        chk("window", dut_win, exp_win);
        chk("s_tready", s_tready, rdy | !exp_valid);
        if (m_tvalid && m_tready) begin
            win_log.push_back(dut_win);
            last_log.push_back(m_tlast);
        end
        acc = 0;
        if (rst) begin
            model_reset();
        end else begin
            deliver = exp_valid && rdy;
            acc     = v && (rdy || !exp_valid);
            loaded  = 0;
            if (acc) begin
                if (u) begin m_active = 1; m_r = 0; m_c = 0; end
                if (m_active) begin
                    img[m_r][m_c] = d;
                    if (m_r >= 2 && m_c >= 2) begin
                        exp_win = {img[m_r-2][m_c-2], img[m_r-2][m_c-1], img[m_r-2][m_c],
                                   img[m_r-1][m_c-2], img[m_r-1][m_c-1], img[m_r-1][m_c],
                                   img[m_r][m_c-2],   img[m_r][m_c-1],   img[m_r][m_c]};
                        exp_valid = 1;
                        exp_last  = (m_r == H - 1) && (m_c == W - 1);
                        loaded    = 1;
                    end
                    if (m_r == H - 1 && m_c == W - 1) begin
                        m_active = 0; m_r = 0; m_c = 0;
                    end else if (m_c == W - 1) begin
                        m_c = 0; m_r++;
                    end else begin
                        m_c++;
                    end
                end
            end
            if (!loaded && deliver) begin exp_valid = 0; exp_last = 0; end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(input logic [7:0] d, input bit u);
        bit acc = 0;
        int tries = 0;
        bit dummy;
        if (gaps && $urandom_range(0, 3) == 0)
            step(0, 8'h00, 0, next_rdy(), 0, dummy);
        while (!acc && tries < 50) begin
            step(1, d, u, next_rdy(), 0, acc);
            tries++;
        end
        n_cmp++;
        assert (acc) else begin
            n_bad++;
            $error("FAIL send_timeout: observed tries %0d expected acceptance", tries);
        end
    endtask

    task automatic send_frame(input bit ramp);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send_pixel(ramp ? 8'(10 * r + c) : 8'($urandom), (r == 0) && (c == 0));
    endtask

    task automatic drain();
        bit dummy;
        for (int i = 0; i < 8; i++) step(0, 8'h00, 0, (i % 2 == 1) || (mode == 0), 0, dummy);
    endtask

    task automatic check_ramp(input string tag);
        chk({tag, "_count"}, win_log.size(), 6);
        chk({tag, "_first"}, win_log[0], RAMP_FIRST);
        chk({tag, "_last"}, win_log[5], RAMP_LAST);
        chk({tag, "_tlast5"}, last_log[5], 1);
        chk({tag, "_tlast0"}, last_log[0], 0);
    endtask

    function automatic int tlast_count();
        int n = 0;
        foreach (last_log[i]) n += last_log[i];
        return n;
    endfunction

    initial begin
        bit dummy;
        s_tvalid = 0; s_tdata = 0; s_tuser = 0; m_tready = 1; rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        step(0, 8'h00, 0, 1, 1, dummy);
        step(0, 8'h00, 0, 1, 0, dummy);

        // Ramp frame, always ready
        mode = 0; win_log.delete(); last_log.delete();
        send_frame(1); drain();
        check_ramp("ramp");

        // Ramp frame with ready toggling 1,0,0,1
        mode = 1; win_log.delete(); last_log.delete();
        send_frame(1); drain();
        check_ramp("stall");

        // Leading pixels without start-of-frame are dropped in IDLE
        mode = 0; win_log.delete(); last_log.delete();
        for (int i = 0; i < 5; i++) send_pixel(8'(100 + i), 0);
        send_frame(1); drain();
        check_ramp("idle_drop");

        // Restart at (2,3): one window from the old frame, then six from the new one
        win_log.delete(); last_log.delete();
        for (int i = 0; i < 13; i++) send_pixel(8'($urandom), i == 0);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                if (r == 2 && c == 2) chk("restart_hold", win_log.size(), 1);
                send_pixel(8'($urandom), (r == 0) && (c == 0));
            end
        drain();
        chk("restart_count", win_log.size(), 7);
        chk("restart_tlast", tlast_count(), 1);

        // Reset while a window is pending and stalled
        win_log.delete(); last_log.delete();
        for (int i = 0; i < 13; i++) send_pixel(8'(10 * (i / W) + i % W), i == 0);
        step(0, 8'h00, 0, 0, 0, dummy);
        chk("pre_reset_valid", m_tvalid, 1);
        step(0, 8'h00, 0, 0, 1, dummy);
        step(0, 8'h00, 0, 1, 0, dummy);
        win_log.delete(); last_log.delete();
        send_frame(1); drain();
        check_ramp("post_reset");

        // Back-to-back frames, s_tvalid held high
        win_log.delete(); last_log.delete();
        send_frame(0); send_frame(0); drain();
        chk("b2b_count", win_log.size(), 12);
        chk("b2b_tlast5", last_log[5], 1);
        chk("b2b_tlast11", last_log[11], 1);
        chk("b2b_tlast_total", tlast_count(), 2);

        // Random ready, random gaps, random data
        mode = 2; gaps = 1; win_log.delete(); last_log.delete();
        repeat (3) send_frame(0);
        mode = 0; drain();
        chk("rand_count", win_log.size(), 18);
        chk("rand_tlast_total", tlast_count(), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sharpen_window_gen.md
SHARPEN_WINDOW_GEN -- requirements
Module: sharpen_window_gen

Interface
REQ-001 Parameter IMG_W, default 64: pixels per line; legal range 3..1024.
REQ-002 Parameter IMG_H, default 64: lines per frame; legal range 3..1024.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 s_tvalid  input  1  input pixel valid.
REQ-006 s_tready  output  1  block accepts a pixel this cycle.
REQ-007 s_tdata  input  8  unsigned input pixel, raster order.
REQ-008 s_tuser  input  1  start of frame, qualifies pixel (0,0).
REQ-009 m_tvalid  output  1  output window valid.
REQ-010 m_tready  input  1  downstream sharpen core accepts the window.
REQ-011 m_p0..m_p8  output  8 each  3x3 window, row-major; m_p0 top-left, m_p4 centre, m_p8 bottom-right.
REQ-012 m_tlast  output  1  marks the last window of a frame.

Function
REQ-013 An input pixel is accepted in any cycle where s_tvalid=1 and s_tready=1; a window is delivered in any cycle where m_tvalid=1 and m_tready=1.
REQ-014 s_tready = m_tready OR NOT m_tvalid; the block has a single output register and no other output buffering.
REQ-015 FSM states: IDLE and ACTIVE; reset state is IDLE.
REQ-016 IDLE: s_tready follows REQ-014; an accepted pixel with s_tuser=0 is discarded; an accepted pixel with s_tuser=1 is pixel (0,0); the block moves to ACTIVE.
REQ-017 ACTIVE: col counter 0..IMG_W-1 increments per accepted pixel; on wrap, col returns to 0 and row increments; acceptance of (IMG_H-1, IMG_W-1) returns the block to IDLE.
REQ-018 An accepted pixel with s_tuser=1 in ACTIVE restarts the frame: it is pixel (0,0); line-buffer contents are not cleared, and no windows are emitted until row>=2.
REQ-019 Two line buffers of IMG_W x 8 bits each: lb_a holds row r-2 and lb_b holds row r-1, indexed by col.
REQ-020 On acceptance of pixel x at (r,c): new column = {lb_a[c], lb_b[c], x}; lb_a[c] <= lb_b[c]; lb_b[c] <= x; the 3x3 window registers shift one column left and take the new column on the right.
REQ-021 If r>=2 and c>=2, the accepted pixel loads the output register with the window centred at (r-1,c-1), including the new column; m_tvalid=1 on the next cycle (latency 1).
REQ-022 m_tlast=1 with the window loaded by pixel (IMG_H-1, IMG_W-1); otherwise m_tlast=0.
REQ-023 Each frame yields exactly (IMG_W-2)*(IMG_H-2) windows; border positions produce no window.
REQ-024 Window columns from the previous line never mix with the current line, because c>=2 gates output.
REQ-025 While m_tvalid=1 and m_tready=0, m_p0..m_p8, m_tlast and m_tvalid are held stable and no pixel is accepted.
REQ-026 After a delivery with no new load in the same cycle, m_tvalid=0 on the next cycle; a delivery and a new load in the same cycle keep m_tvalid=1 with the new window.
REQ-027 All arithmetic is unsigned; counters are sized ceil(log2(max dimension)) bits; pixel data passes through unmodified.

Reset
REQ-028 When rst_n=0 at a clock edge: FSM enters IDLE; row=0, col=0; m_tvalid=0, m_tlast=0; m_p0..m_p8=0; window registers are 0.
REQ-029 Line-buffer RAM contents are not reset.
REQ-030 Reset asserted mid-frame discards any pending output window; after reset release, the block waits for s_tuser=1.

Verification
REQ-031 Ramp frame, IMG_W=5, IMG_H=4, pixel=10r+c, m_tready=1 -> 6 windows; first window is 0,1,2,10,11,12,20,21,22; last window is 12,13,14,22,23,24,32,33,34 with m_tlast=1.
REQ-032 Same frame with m_tready toggling 1,0,0,1 -> identical window sequence; outputs stable while stalled; s_tready=0 during each stall with m_tvalid=1.
REQ-033 Five pixels with s_tuser=0 in IDLE, then the REQ-031 frame -> the leading pixels are dropped and the output matches REQ-031 exactly.
REQ-034 s_tuser=1 reasserted at pixel (2,3) of a frame -> counters restart; the next window appears only after the new frame reaches (2,2).
REQ-035 rst_n=0 for one cycle while m_tvalid=1 -> the next cycle shows m_tvalid=0 and all outputs 0; a following full frame gives the REQ-031 results.
REQ-036 Two back-to-back frames with s_tvalid held at 1 -> 12 windows; m_tlast on the 6th and 12th windows.
